rs_syndrome: RTL and testbench

Syndrome calculator, first stage of the RS(255,239) decoder over GF(2^8) that receives codewords produced by the RS encoder chain. Accepts one received symbol per valid cycle, evaluates the received polynomial at the 16 generator roots by Horner's rule, and presents all 16 syndromes plus an error flag one cycle after the last symbol. Output feeds the key-equation solver; no backpressure.

---
 rtl/rs_syndrome.sv | 141 ++++++++++++++
 tb/tb_rs_syndrome.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome.sv
// RS(255,239) syndrome calculator over GF(2^8), primitive polynomial 0x11D.
// Horner evaluation of the received word at alpha^(FCR+i) for all NSYM roots.
module rs_syndrome #(
    parameter int N    = 255,
    parameter int NSYM = 16,
    parameter int FCR  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    input  logic                din_sop,
    input  logic [7:0]          din,
    output logic [8*NSYM-1:0]   synd,
    output logic                synd_valid,
    output logic                err_flag,
    output logic                frame_err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ ({8{a[7]}} & 8'h1D);
    endfunction

    // With a constant operand b this reduces to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            p = p ^ (t & {8{b[k]}});
            t = gf_xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < (e % 255); k++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    function automatic logic [8*NSYM-1:0] gf_roots();
        logic [8*NSYM-1:0] r;
        r = '0;
        for (int i = 0; i < NSYM; i++) begin
            r[8*i +: 8] = gf_alpha_pow(FCR + i);
        end
        return r;
    endfunction

    localparam logic [8*NSYM-1:0] ROOTS = gf_roots();

    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_next_s;
    logic [8*NSYM-1:0]  acc_r;
    logic [8*NSYM-1:0]  acc_next_s;
    logic [8*NSYM-1:0]  synd_r;
    logic               synd_valid_r;
    logic               err_flag_r;
    logic               frame_err_r;
    logic               first_s;
    logic               abort_s;
    logic               done_s;

    // Framing: counter-based start, din_sop only forces a resync.
    always_comb begin
        first_s    = (cnt_r == CNT_ZERO) || din_sop;
        abort_s    = din_valid && din_sop && (cnt_r != CNT_ZERO);
        done_s     = din_valid && !first_s && (cnt_r == CNT_LAST);
        cnt_next_s = cnt_r;
        if (!din_valid) begin
            cnt_next_s = cnt_r;
        end else if (done_s) begin
            cnt_next_s = CNT_ZERO;
        end else if (first_s) begin
            cnt_next_s = CNT_ONE;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Horner step per syndrome lane; the first symbol of a word reloads the lane.
    always_comb begin
        acc_next_s = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (first_s) begin
                acc_next_s[8*i +: 8] = din;
            end else begin
                acc_next_s[8*i +: 8] = gf_mul(acc_r[8*i +: 8], ROOTS[8*i +: 8]) ^ din;
            end
        end
    end

    // Symbol counter and accumulators advance only on accepted symbols.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
            acc_r <= '0;
        end else if (din_valid) begin
            cnt_r <= cnt_next_s;
            acc_r <= acc_next_s;
        end else begin
            cnt_r <= cnt_r;
            acc_r <= acc_r;
        end
    end

    // Result registers: captured on completion, held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            synd_r       <= '0;
            synd_valid_r <= 1'b0;
            err_flag_r   <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            synd_valid_r <= done_s;
            frame_err_r  <= abort_s;
            if (done_s) begin
                synd_r     <= acc_next_s;
                err_flag_r <= |acc_next_s;
            end else begin
                synd_r     <= synd_r;
                err_flag_r <= err_flag_r;
            end
        end
    end

    assign synd       = synd_r;
    assign synd_valid = synd_valid_r;
    assign err_flag   = err_flag_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_rs_syndrome.sv
// Directed self-checking bench for rs_syndrome (N=255, NSYM=16, FCR=0).
module tb_rs_syndrome;

    localparam logic [127:0] EXP_X1 = {8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D,
                                       8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    localparam logic [127:0] EXP_X2 = {8'h60, 8'h18, 8'h06, 8'h8F, 8'hEA, 8'hB4, 8'h2D, 8'h4C,
                                       8'h13, 8'hCD, 8'h74, 8'h1D, 8'h40, 8'h10, 8'h04, 8'h01};
    localparam logic [127:0] EXP_5A = {16{8'h5A}};
    localparam logic [127:0] EXP_Z  = 128'h0;

    logic         clk;
    logic         rst;
    logic         din_valid;
    logic         din_sop;
    logic [7:0]   din;
    logic [127:0] synd;
    logic         synd_valid;
    logic         err_flag;
    logic         frame_err;

    int           n_checks;
    int           n_fail;
    int           sv_pulses;
    int           fe_pulses;
    logic [7:0]   word [0:254];
    logic [127:0] exp_hold;

    rs_syndrome dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .din        (din),
        .synd       (synd),
        .synd_valid (synd_valid),
        .err_flag   (err_flag),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses on the falling edge.
    always @(negedge clk) begin
        if (synd_valid === 1'b1) sv_pulses <= sv_pulses + 1;
        if (frame_err === 1'b1) fe_pulses <= fe_pulses + 1;
    end

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ ({8{a[7]}} & 8'h1D);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = gf_xtime(t);
        end
        return p;
    endfunction

    task automatic build_zero();
        for (int i = 0; i < 255; i++) word[i] = 8'h00;
    endtask

    // Systematic RS(255,239) encoding of message bytes 0x01..0xEF.
    task automatic build_encoded();
        logic [7:0] g [0:16];
        logic [7:0] par [0:15];
        logic [7:0] r;
        logic [7:0] fb;
        logic [7:0] d;
        for (int k = 0; k <= 16; k++) g[k] = 8'h00;
        g[0] = 8'h01;
        r = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int k = 16; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], r);
            g[0] = gf_mul(g[0], r);
            r = gf_xtime(r);
        end
        for (int j = 0; j < 16; j++) par[j] = 8'h00;
        for (int k = 0; k < 239; k++) begin
            d = 8'(k + 1);
            word[k] = d;
            fb = d ^ par[15];
            for (int j = 15; j >= 1; j--) par[j] = par[j-1] ^ gf_mul(fb, g[j]);
            par[0] = gf_mul(fb, g[0]);
        end
        for (int j = 0; j < 16; j++) word[239 + j] = par[15 - j];
    endtask

    task automatic build_word(input int kind);
        build_zero();
        case (kind)
            0: word[253] = 8'h01;
            1: begin
                build_encoded();
                word[254] = word[254] ^ 8'h5A;
            end
            2: word[252] = 8'h01;
            default: build_zero();
        endcase
    endtask

    // Drives word[lo..hi-1] with optional random idle gaps; checks synd is held mid-word.
    task automatic send_range(input int lo, input int hi, input int gap_max,
                              input bit use_sop, input logic [127:0] hold_val);
        int gp;
        for (int i = lo; i < hi; i++) begin
            gp = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gp) begin
                @(negedge clk);
                din_valid = 1'b0;
                din_sop   = 1'($urandom);
                din       = 8'($urandom);
            end
            @(negedge clk);
            if (i == 128) begin
                n_checks++;
                if (synd !== hold_val) begin
                    n_fail++;
                    $display("FAIL synd_hold: got %h expected %h", synd, hold_val);
                end
            end
            din_valid = 1'b1;
            din_sop   = use_sop && (i == 0);
            din       = word[i];
        end
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din       = 8'h00;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (synd !== EXP_Z) begin n_fail++; $display("FAIL reset_synd: got %h expected 0", synd); end
        n_checks++;
        if (synd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_synd_valid: got %b expected 0", synd_valid); end
        n_checks++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag: got %b expected 0", err_flag); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_word();
        build_zero();
        send_range(0, 255, 0, 1'b1, EXP_Z);
        n_checks++;
        if (synd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_early_valid: got %b expected 0", synd_valid); end
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b expected 1", synd_valid); end
        n_checks++;
        if (synd !== EXP_Z) begin n_fail++; $display("FAIL zero_synd: got %h expected 0", synd); end
        n_checks++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b expected 0", err_flag); end
        idle();
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_width: got %b expected 0", synd_valid); end
        exp_hold = EXP_Z;
    endtask

    task automatic test_encoder();
        build_encoded();
        send_range(0, 255, 0, 1'b1, exp_hold);
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b1 || synd !== EXP_Z || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_clean: got v=%b s=%h e=%b expected v=1 s=0 e=0", synd_valid, synd, err_flag);
        end
        idle();
        exp_hold = EXP_Z;
        word[254] = word[254] ^ 8'h5A;
        send_range(0, 255, 0, 1'b1, exp_hold);
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b1 || synd !== EXP_5A || err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL enc_5a: got v=%b s=%h e=%b expected v=1 s=%h e=1", synd_valid, synd, err_flag, EXP_5A);
        end
        idle();
        exp_hold = EXP_5A;
    endtask

    task automatic test_single_error();
        build_word(0);
        send_range(0, 255, 0, 1'b1, exp_hold);
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b1 || synd !== EXP_X1 || err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL single_x1: got v=%b s=%h e=%b expected v=1 s=%h e=1", synd_valid, synd, err_flag, EXP_X1);
        end
        idle();
        exp_hold = EXP_X1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_s [0:2];
        int p0;
        exp_s[0] = EXP_X1;
        exp_s[1] = EXP_5A;
        exp_s[2] = EXP_X2;
        for (int rnd = 0; rnd < 2; rnd++) begin
            #1 p0 = sv_pulses;
            for (int w = 0; w < 3; w++) begin
                build_word(w);
                send_range(0, 255, (rnd == 0) ? 0 : 3, rnd == 0, exp_hold);
                @(posedge clk);
                #1;
                n_checks++;
                if (synd_valid !== 1'b1 || synd !== exp_s[w] || err_flag !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_r%0d_w%0d: got v=%b s=%h e=%b expected v=1 s=%h e=1",
                             rnd, w, synd_valid, synd, err_flag, exp_s[w]);
                end
                exp_hold = exp_s[w];
            end
            idle();
            repeat (2) @(posedge clk);
            #1;
            n_checks++;
            if (sv_pulses - p0 !== 3) begin
                n_fail++;
                $display("FAIL b2b_pulse_count_r%0d: got %0d expected 3", rnd, sv_pulses - p0);
            end
        end
    endtask

    task automatic test_abort();
        int p0;
        int f0;
        #1;
        p0 = sv_pulses;
        f0 = fe_pulses;
        build_word(2);
        send_range(0, 100, 0, 1'b1, exp_hold);
        build_word(0);
        send_range(0, 1, 0, 1'b1, exp_hold);
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_err !== 1'b1 || synd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse: got fe=%b v=%b expected fe=1 v=0", frame_err, synd_valid);
        end
        send_range(1, 255, 0, 1'b1, exp_hold);
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b1 || synd !== EXP_X1 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_resync: got v=%b s=%h fe=%b expected v=1 s=%h fe=0", synd_valid, synd, frame_err, EXP_X1);
        end
        exp_hold = EXP_X1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sv_pulses - p0 !== 1 || fe_pulses - f0 !== 1) begin
            n_fail++;
            $display("FAIL abort_counts: got v=%0d fe=%0d expected v=1 fe=1", sv_pulses - p0, fe_pulses - f0);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        int f0;
        #1;
        p0 = sv_pulses;
        f0 = fe_pulses;
        build_word(2);
        send_range(0, 150, 0, 1'b1, exp_hold);
        @(negedge clk);
        rst = 1'b1;
        din = word[150];
        @(posedge clk);
        #1;
        n_checks++;
        if (synd !== EXP_Z || err_flag !== 1'b0 || synd_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got s=%h e=%b v=%b fe=%b expected all 0", synd, err_flag, synd_valid, frame_err);
        end
        idle();
        @(negedge clk);
        rst = 1'b0;
        build_zero();
        send_range(0, 255, 0, 1'b1, EXP_Z);
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b1 || synd !== EXP_Z || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_zero_word: got v=%b s=%h e=%b expected v=1 s=0 e=0", synd_valid, synd, err_flag);
        end
        build_word(0);
        send_range(0, 254, 0, 1'b1, EXP_Z);
        @(negedge clk);
        rst = 1'b1;
        din = word[254];
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b0 || synd !== EXP_Z) begin
            n_fail++;
            $display("FAIL rst_wins: got v=%b s=%h expected v=0 s=0", synd_valid, synd);
        end
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sv_pulses - p0 !== 1 || fe_pulses - f0 !== 0) begin
            n_fail++;
            $display("FAIL rst_counts: got v=%0d fe=%0d expected v=1 fe=0", sv_pulses - p0, fe_pulses - f0);
        end
        build_word(0);
        send_range(0, 255, 0, 1'b1, EXP_Z);
        @(posedge clk);
        #1;
        n_checks++;
        if (synd_valid !== 1'b1 || synd !== EXP_X1 || err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after_word: got v=%b s=%h e=%b expected v=1 s=%h e=1", synd_valid, synd, err_flag, EXP_X1);
        end
        idle();
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din       = 8'h00;
        n_checks  = 0;
        n_fail    = 0;
        sv_pulses = 0;
        fe_pulses = 0;
        exp_hold  = EXP_Z;
        test_reset();
        test_zero_word();
        test_encoder();
        test_single_error();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
